bcd_alarm_timekeeper: RTL

- Parametrised successor to the single-alarm BCD clock core.
- Keeps 24-hour packed-BCD time HH:MM:SS:CC with a configurable tick rate.
- Holds NUM_ALARMS independently enabled alarms, with snooze, dismiss and ring timeout.
- Also outputs a 12/24-hour display copy. Feeds the seven-segment decoder and the PDM audio player; play_start is the player trigger.

---
 rtl/bcd_clock_pkg.sv | 31 +++
 rtl/bcd_time_add.sv | 31 +++
 rtl/bcd_alarm_timekeeper.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_clock_pkg.sv
// rtl/bcd_clock_pkg.sv - field codes, BCD limits, alarm FSM states and BCD helpers
package bcd_clock_pkg;
  localparam logic [1:0] FIELD_CC = 2'd0;
  localparam logic [1:0] FIELD_SS = 2'd1;
  localparam logic [1:0] FIELD_MM = 2'd2;
  localparam logic [1:0] FIELD_HH = 2'd3;

  localparam logic [7:0] MAX_HH = 8'h23;
  localparam logic [7:0] MAX_MS = 8'h59;
  localparam logic [7:0] MAX_CC = 8'h99;

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} alarm_state_t;

  // Packed BCD compares like binary once both nibbles are decimal digits.
  function automatic logic bcd_valid(input logic [7:0] value, input logic [7:0] max);
    return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= max);
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] value);
    if (value[3:0] == 4'd9) return {value[7:4] + 4'd1, 4'd0};
    return {value[7:4], value[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] bcd2bin(input logic [7:0] value);
    return 7'(value[7:4]) * 7'd10 + 7'(value[3:0]);
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [6:0] value);
    return {4'(value / 7'd10), 4'(value % 7'd10)};
  endfunction
endpackage

// File: rtl/bcd_time_add.sv
// rtl/bcd_time_add.sv - adds a fixed number of minutes to a BCD HH:MM:SS with hour and day wrap
module bcd_time_add
  import bcd_clock_pkg::*;
#(
  parameter int ADD_MIN = 5
) (
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  output logic [7:0] sum_hh,
  output logic [7:0] sum_mm,
  output logic [7:0] sum_ss
);
  logic [6:0] mm_sum;
  logic [6:0] hh_sum;

  // ADD_MIN is below an hour, so at most one hour carry is possible.
  always_comb begin
    mm_sum = bcd2bin(mm) + 7'(ADD_MIN);
    hh_sum = bcd2bin(hh);
    if (mm_sum >= 7'd60) begin
      mm_sum = mm_sum - 7'd60;
      hh_sum = hh_sum + 7'd1;
    end
    if (hh_sum >= 7'd24) hh_sum = hh_sum - 7'd24;
    sum_mm = bin2bcd(mm_sum);
    sum_hh = bin2bcd(hh_sum);
  end

  assign sum_ss = ss;
endmodule

// File: rtl/bcd_alarm_timekeeper.sv
// rtl/bcd_alarm_timekeeper.sv - 24-hour BCD timekeeper with multiple alarms, snooze and ring timeout
module bcd_alarm_timekeeper
  import bcd_clock_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int TICK_HZ = 100,
  parameter int NUM_ALARMS = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_TIMEOUT_S = 60,
  localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [7:0]            time_in,
  input  logic [1:0]            field_sel,
  input  logic                  wr_time,
  input  logic                  wr_alarm,
  input  logic [AW-1:0]         alarm_sel,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  input  logic                  mode_12h,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic [31:0]           time_bcd,
  output logic [31:0]           disp_bcd,
  output logic                  pm,
  output logic                  tick,
  output logic                  wr_err,
  output logic                  ringing,
  output logic [AW-1:0]         ring_id,
  output logic                  play_start
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [7:0] hh, mm, ss, cc;
  logic [PW-1:0] presc;
  logic [7:0] al_hh [NUM_ALARMS];
  logic [7:0] al_mm [NUM_ALARMS];
  logic [7:0] al_ss [NUM_ALARMS];
  logic [7:0] tgt_hh, tgt_mm, tgt_ss;
  logic [7:0] snz_hh, snz_mm, snz_ss;
  logic [7:0] to_cnt;
  alarm_state_t state;

  logic [7:0] lim;
  logic fld_ok, time_ok, alarm_ok, reject;
  logic tc, advance, sec_evt, hit, snz_hit;
  logic [AW-1:0] hit_idx;
  logic [7:0] n_hh, n_mm, n_ss, n_cc;
  logic [7:0] disp_hh;

  always_comb begin
    case (field_sel)
      FIELD_HH: lim = MAX_HH;
      FIELD_CC: lim = MAX_CC;
      default:  lim = MAX_MS;
    endcase
  end

  assign fld_ok   = bcd_valid(time_in, lim);
  assign time_ok  = wr_time && fld_ok;
  assign alarm_ok = wr_alarm && (field_sel != FIELD_CC) && fld_ok && (int'(alarm_sel) < NUM_ALARMS);
  assign reject   = (wr_time && !fld_ok) || (wr_alarm && (field_sel != FIELD_CC) && !fld_ok);

  // A valid time write owns the cycle: no tick, no advance, prescaler restarts.
  assign tc      = (presc == PW'(DIV - 1));
  assign advance = tc && !time_ok;
  assign sec_evt = advance && (cc == MAX_CC);

  always_comb begin
    n_cc = (cc == MAX_CC) ? 8'h00 : bcd_inc(cc);
    n_ss = ss;
    n_mm = mm;
    n_hh = hh;
    if (cc == MAX_CC) begin
      n_ss = (ss == MAX_MS) ? 8'h00 : bcd_inc(ss);
      if (ss == MAX_MS) begin
        n_mm = (mm == MAX_MS) ? 8'h00 : bcd_inc(mm);
        if (mm == MAX_MS) n_hh = (hh == MAX_HH) ? 8'h00 : bcd_inc(hh);
      end
    end
  end

  // Descending scan leaves the lowest matching index in hit_idx.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
      if (alarm_en[k] && ({al_hh[k], al_mm[k], al_ss[k]} == {n_hh, n_mm, n_ss})) begin
        hit     = 1'b1;
        hit_idx = AW'(k);
      end
    end
    hit = hit && sec_evt;
  end

  assign snz_hit = sec_evt && ({tgt_hh, tgt_mm, tgt_ss} == {n_hh, n_mm, n_ss});

  bcd_time_add #(.ADD_MIN(SNOOZE_MIN)) u_snooze_add (
    .hh     (hh),
    .mm     (mm),
    .ss     (ss),
    .sum_hh (snz_hh),
    .sum_mm (snz_mm),
    .sum_ss (snz_ss)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      {hh, mm, ss, cc} <= '0;
      presc  <= '0;
      tick   <= 1'b0;
      wr_err <= 1'b0;
      for (int k = 0; k < NUM_ALARMS; k++) begin
        al_hh[k] <= 8'h00;
        al_mm[k] <= 8'h00;
        al_ss[k] <= 8'h00;
      end
    end else begin
      tick   <= advance;
      wr_err <= reject;
      if (time_ok || tc) presc <= '0;
      else               presc <= presc + PW'(1);
      if (time_ok) begin
        case (field_sel)
          FIELD_CC: cc <= time_in;
          FIELD_SS: ss <= time_in;
          FIELD_MM: mm <= time_in;
          default:  hh <= time_in;
        endcase
      end else if (advance) begin
        {hh, mm, ss, cc} <= {n_hh, n_mm, n_ss, n_cc};
      end
      if (alarm_ok) begin
        case (field_sel)
          FIELD_SS: al_ss[alarm_sel] <= time_in;
          FIELD_MM: al_mm[alarm_sel] <= time_in;
          FIELD_HH: al_hh[alarm_sel] <= time_in;
          default:  ;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      ringing    <= 1'b0;
      ring_id    <= '0;
      play_start <= 1'b0;
      to_cnt     <= 8'd0;
      {tgt_hh, tgt_mm, tgt_ss} <= '0;
    end else begin
      play_start <= 1'b0;
      case (state)
        IDLE: if (hit) begin
          state      <= RING;
          ringing    <= 1'b1;
          ring_id    <= hit_idx;
          play_start <= 1'b1;
          to_cnt     <= 8'd0;
        end
        RING: if (dismiss) begin
          state   <= IDLE;
          ringing <= 1'b0;
        end else if (snooze) begin
          state   <= SNOOZE;
          ringing <= 1'b0;
          {tgt_hh, tgt_mm, tgt_ss} <= {snz_hh, snz_mm, snz_ss};
        end else if (sec_evt) begin
          if (to_cnt == 8'(RING_TIMEOUT_S - 1)) begin
            state   <= IDLE;
            ringing <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        SNOOZE: if (dismiss) begin
          state <= IDLE;
        end else if (hit || snz_hit) begin
          state      <= RING;
          ringing    <= 1'b1;
          play_start <= 1'b1;
          to_cnt     <= 8'd0;
          if (hit) ring_id <= hit_idx;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    disp_hh = hh;
    if (mode_12h) begin
      if (hh == 8'h00)      disp_hh = 8'h12;
      else if (hh > 8'h12)  disp_hh = bin2bcd(bcd2bin(hh) - 7'd12);
    end
  end

  assign time_bcd = {hh, mm, ss, cc};
  assign disp_bcd = {disp_hh, mm, ss, cc};
  assign pm       = (hh >= 8'h12);
endmodule
